// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   - state_t    : FSM state encoding (ST_IDLE=0, ST_SHIFT=1, ST_DONE=2)
//   - DEF_WIDTH  : default operand/sum width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa.sv
// -----------------------------------------------------------------------------
// serial_adder_fa
//   One-bit full-adder cell, purely combinational.
//   Ports:
//     a, b  : operand bits
//     ci    : carry in
//     s     : sum bit
//     co    : carry out
// -----------------------------------------------------------------------------
module serial_adder_fa
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : serial_adder_fa

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are streamed LSB-first through a
//   single full-adder cell, one bit per clock, with a carry flip-flop closing
//   the carry loop. Result {cout,sum} = a + b + cin.
//
//   Parameters:
//     WIDTH : operand/sum width, legal range 2..32
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : synchronous active-low reset
//     start  : request a new addition, sampled only in IDLE
//     a, b   : operands, captured on the accepted start
//     cin    : carry-in, captured on the accepted start
//     busy   : high while in SHIFT or DONE
//     done   : one-cycle pulse, sum/cout valid
//     sum    : registered result, held until the next result
//     cout   : registered carry-out of the MSB
//     ovf    : signed overflow, only with SERIAL_ADDER_OVF_EN defined
//
//   Handshake: start is accepted on a rising edge when the FSM is in IDLE;
//   start seen while busy is dropped (no queueing). done pulses exactly one
//   cycle, after which the FSM is back in IDLE and can accept a new start on
//   that same IDLE cycle.
//
//   Optional macro: SERIAL_ADDER_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   sum_sr;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_co;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_next;

  serial_adder_fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // The new sum bit enters at the MSB so that after WIDTH shifts the LSB
  // computed first has reached bit 0.
  assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // State register and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_next;
          carry_q <= fa_co;
          cnt     <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= sum_next;
            cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB during the last bit cycle.
            ovf  <= carry_q ^ fa_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8): directed vector table,
//   hand-written multi-cycle sequences and randomized operands checked
//   against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic dut_ovf();
`ifdef SERIAL_ADDER_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: plain arithmetic on the operands.
  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int r;
    r = int'($signed(a)) + int'($signed(b)) + int'(c);
    return (r > 127) || (r < -128);
  endfunction

  // ---------------- driver ----------------
  // Issues one start pulse from IDLE, scrambles the operands after capture,
  // and waits (bounded) for done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output int lat, output int busy_cycles,
                        output logic post_done, output logic post_busy, output logic [W-1:0] post_sum);
    s = 'x; co = 1'bx; ov = 1'bx; lat = -1; busy_cycles = 0;
    @(negedge clk);
    a_i = a; b_i = b; cin_i = c; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
      end
      if (busy) busy_cycles++;
      if (done) begin
        s = sum; co = cout; ov = dut_ovf(); lat = k;
        break;
      end
    end
    if (lat < 0) chk("op_timeout", 32'd1, 32'd0);
    @(negedge clk);
    post_done = done; post_busy = busy; post_sum = sum;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] s, psum;
    logic co, ov, pdone, pbusy;
    logic [W:0] m;
    int lat, bc;
    int done_cnt;
    int done_at[$];

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf",  32'(ovf),  32'd0);
`endif
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, s, co, ov, lat, bc, pdone, pbusy, psum);
      chk($sformatf("vec%0d_sum", i),  32'(s),  32'(vecs[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].co));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("vec%0d_ovf", i),  32'(ov), 32'(vecs[i].ov));
`endif
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(W + 1));
      chk($sformatf("vec%0d_done_one_cycle", i), 32'(pdone), 32'd0);
      chk($sformatf("vec%0d_idle_after", i), 32'(pbusy), 32'd0);
      chk($sformatf("vec%0d_sum_hold", i), 32'(psum), 32'(vecs[i].s));
    end

    // ---------------- start re-pulsed mid-SHIFT ----------------
    @(negedge clk);
    a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0; s = 'x;
    for (int k = 2; k <= 20; k++) begin
      if (k == 3) begin start = 1'b1; a_i = 8'hFF; b_i = 8'hEE; cin_i = 1'b1; end
      if (k == 5) start = 1'b0;
      if (done) begin done_cnt++; s = sum; co = cout; end
      @(negedge clk);
    end
    chk("restart_sum", 32'(s), 32'h46);
    chk("restart_cout", 32'(co), 32'd0);
    chk("restart_done_count", 32'(done_cnt), 32'd1);

    // ---------------- reset during SHIFT ----------------
    @(negedge clk);
    a_i = 8'h33; b_i = 8'h44; cin_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    done_cnt = 0;
    repeat (12) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    run_op(8'h0F, 8'h01, 1'b0, s, co, ov, lat, bc, pdone, pbusy, psum);
    chk("postrst_sum", 32'(s), 32'h10);
    chk("postrst_cout", 32'(co), 32'd0);

    // ---------------- start held continuously ----------------
    @(negedge clk);
    a_i = 8'h01; b_i = 8'h01; cin_i = 1'b0; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(k);
        chk($sformatf("held_sum_%0d", k), 32'(sum), 32'h02);
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_at.size()), 32'd3);
    for (int i = 1; i < done_at.size(); i++)
      chk($sformatf("held_period_%0d", i), 32'(done_at[i] - done_at[i-1]), 32'(W + 2));
    begin
      int guard;
      guard = 0;
      while (busy && guard < 20) begin @(negedge clk); guard++; end
      chk("held_return_idle", 32'(busy), 32'd0);
    end

    // ---------------- randomized vs model ----------------
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(1, 0));
      run_op(ra, rb, rc, s, co, ov, lat, bc, pdone, pbusy, psum);
      m = model_sum(ra, rb, rc);
      chk($sformatf("rnd%0d_sum %h+%h+%b", n, ra, rb, rc), 32'(s), 32'(m[W-1:0]));
      chk($sformatf("rnd%0d_cout", n), 32'(co), 32'(m[W]));
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("rnd%0d_ovf", n), 32'(ov), 32'(model_ovf(ra, rb, rc)));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that streams operand bits LSB-first, one bit per clock, through a single one-bit full-adder cell.
- A registered carry flip-flop closes the carry loop between bits.
- Sits directly upstream of the full-adder cell: it owns the operand and sum shift registers, the carry register, the bit counter and the start/done handshake.
- Target use: the next lab step, adding multi-bit operands with only one adder cell.

Parameters:
- WIDTH, 8: operand and sum width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH): bit-counter width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; sum and cout are valid when high.
- sum  output  WIDTH  registered result; holds until the next result.
- cout  output  1  registered carry-out of the MSB; holds with sum.

Behaviour:
- Reset: one clock edge with rst_n=0 forces the following.
  - State returns to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry register and counter clear.
  - Reset overrides everything, including reset mid-SHIFT: the operation is abandoned and no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - start=1 at edge t0: load a_sr<=a, b_sr<=b, carry_q<=cin, cnt<=0; go to SHIFT.
- SHIFT, once per edge:
  - The cell takes a_sr[0], b_sr[0] and carry_q.
  - a_sr and b_sr shift right by one.
  - The cell's sum bit enters the MSB of sum_sr, which also shifts right.
  - carry_q<=cell carry-out; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: sum<=final sum_sr, cout<=final carry, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy still 1.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - start sampled at t0; WIDTH bit operations at edges t1..tWIDTH.
  - done high in the cycle after edge t0+WIDTH.
  - Back-to-back throughput is one result per WIDTH+2 cycles.
- start rules:
  - start while busy (SHIFT or DONE) is ignored; no queueing.
  - start held continuously restarts on the first IDLE cycle after DONE.
- Operand changes: a, b and cin may change freely after capture without affecting the result.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1); no truncation errors.
- Outputs sum and cout change only on DONE entry or reset.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered with sum.
  - ovf = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow.
  - The carry-into-MSB is captured during the last SHIFT cycle.
  - ovf resets to 0.
- When undefined: no ovf port and no extra flop; all other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default WIDTH constant.
- One sub-module is natural: the existing one-bit full-adder cell, instantiated once as u_fa.
- Control, counter and shift registers stay in serial_adder.

Test Plan (WIDTH=8):
- a=0x00, b=0x00, cin=0, start pulse -> done after 8 bit cycles; sum=0x00, cout=0; busy high exactly 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN: ovf=0.
- a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1; then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 when enabled.
- a=0x12, b=0x34 started; start re-pulsed mid-SHIFT with a=0xFF and operands changed -> result still 0x46, cout=0, exactly one done pulse.
- rst_n low for one edge at bit cycle 4 -> next cycle busy=0, sum=0, cout=0, no done; a fresh start of 0x0F+0x01 then yields 0x10.
- start held high for 30 cycles with a=0x01, b=0x01 -> done pulses at a 10-cycle period, sum=0x02 each time.
